sfx_player: RTL and testbench

Sound-effect sequencer for the pong game. It sits directly upstream of the board speaker pin, in place of the two free-running tone instances and the combinational sound mux. The game FSM pulses `hit_trig` on a paddle hit or `over_trig` on game over. The block then plays a short fixed note sequence as a square wave on `speaker` and reports `busy` and `done` back to the FSM.

---
 rtl/sfx_pkg.sv | 43 ++++
 rtl/sfx_player_sq_tone_gen.sv | 39 +++
 rtl/sfx_player.sv | 178 +++++++++++++++++
 tb/tb_sfx_player.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// sfx_pkg: shared constants for the pong sound-effect sequencer.
// Sequence IDs, FSM encoding, note table values and the period helper.
package sfx_pkg;

    localparam logic [1:0] SFX_NONE = 2'd0;
    localparam logic [1:0] SFX_HIT  = 2'd1;
    localparam logic [1:0] SFX_OVER = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NOTE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int F_HIT0  = 880;
    localparam int F_HIT1  = 1320;
    localparam int F_OVER0 = 523;
    localparam int F_OVER1 = 392;
    localparam int F_OVER2 = 330;
    localparam int F_OVER3 = 262;

    localparam logic [8:0] D_HIT0  = 9'd40;
    localparam logic [8:0] D_HIT1  = 9'd40;
    localparam logic [8:0] D_OVER0 = 9'd150;
    localparam logic [8:0] D_OVER1 = 9'd150;
    localparam logic [8:0] D_OVER2 = 9'd150;
    localparam logic [8:0] D_OVER3 = 9'd300;

    localparam int HIT_LEN  = 2;
    localparam int OVER_LEN = 4;

    localparam logic [8:0] GAP_MS = 9'd10;

    typedef struct packed {
        logic [17:0] half;
        logic [8:0]  len;
    } note_t;

    function automatic logic [17:0] half_period(input int clk_freq, input int f);
        int h;
        h = clk_freq / (2 * f);
        return h[17:0];
    endfunction

endpackage

// File: rtl/sfx_player_sq_tone_gen.sv
// sq_tone_gen: square wave from a half-period count.
// clear restarts the wave low; while disabled the output holds low.
module sq_tone_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [17:0] half,
    output logic        speaker
);

    logic [17:0] cnt_q, cnt_d;
    logic        spk_q, spk_d;

    always_comb begin
        cnt_d = cnt_q + 18'd1;
        spk_d = spk_q;
        if (clear || !enable) begin
            cnt_d = '0;
            spk_d = 1'b0;
        end else if (cnt_q == half - 18'd1) begin
            cnt_d = '0;
            spk_d = ~spk_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            spk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            spk_q <= spk_d;
        end
    end

    assign speaker = spk_q;

endmodule

// File: rtl/sfx_player.sv
// sfx_player: plays hit / game-over jingles as a square wave.
// Define SFX_GAP_EN to insert a silent gap after every note.
module sfx_player #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit_trig,
    input  logic       over_trig,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] active_sfx,
    output logic       done
);

    import sfx_pkg::*;

    localparam logic [16:0] TICK_MAX = 17'(CLK_FREQ / 1000 - 1);

    localparam logic [17:0] H_HIT0  = half_period(CLK_FREQ, F_HIT0);
    localparam logic [17:0] H_HIT1  = half_period(CLK_FREQ, F_HIT1);
    localparam logic [17:0] H_OVER0 = half_period(CLK_FREQ, F_OVER0);
    localparam logic [17:0] H_OVER1 = half_period(CLK_FREQ, F_OVER1);
    localparam logic [17:0] H_OVER2 = half_period(CLK_FREQ, F_OVER2);
    localparam logic [17:0] H_OVER3 = half_period(CLK_FREQ, F_OVER3);

    function automatic note_t note_rom(input logic [1:0] sfx, input logic [1:0] idx);
        note_t n;
        n.half = H_HIT0;
        n.len  = D_HIT0;
        if (sfx == SFX_OVER) begin
            case (idx)
                2'd0: begin n.half = H_OVER0; n.len = D_OVER0; end
                2'd1: begin n.half = H_OVER1; n.len = D_OVER1; end
                2'd2: begin n.half = H_OVER2; n.len = D_OVER2; end
                default: begin n.half = H_OVER3; n.len = D_OVER3; end
            endcase
        end else if (idx == 2'd1) begin
            n.half = H_HIT1;
            n.len  = D_HIT1;
        end
        return n;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  sfx_q, sfx_d;
    logic [1:0]  idx_q, idx_d;
    logic [17:0] half_q, half_d;
    logic [8:0]  len_q, len_d;
    logic [16:0] presc_q, presc_d;
    logic [8:0]  dur_q, dur_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        load;
    logic        seg_end;
    logic        adv;
    logic [8:0]  dur_nxt;
    logic [8:0]  seg_len;
    logic [1:0]  last_idx;
    note_t       nxt;

    always_comb begin
        state_d  = state_q;
        sfx_d    = sfx_q;
        idx_d    = idx_q;
        half_d   = half_q;
        len_d    = len_q;
        presc_d  = presc_q;
        dur_d    = dur_q;
        done_d   = 1'b0;
        load     = 1'b0;
        seg_end  = 1'b0;
        adv      = 1'b0;
        nxt      = '0;
        dur_nxt  = dur_q + 9'd1;
        seg_len  = (state_q == ST_NOTE) ? len_q : GAP_MS;
        last_idx = (sfx_q == SFX_OVER) ? 2'(OVER_LEN - 1) : 2'(HIT_LEN - 1);

        if (state_q != ST_IDLE) begin
            if (presc_q == TICK_MAX) begin
                presc_d = '0;
                if (dur_nxt == seg_len) begin
                    seg_end = 1'b1;
                end else begin
                    dur_d = dur_nxt;
                end
            end else begin
                presc_d = presc_q + 17'd1;
            end
        end

`ifdef SFX_GAP_EN
        if (seg_end && state_q == ST_NOTE) begin
            state_d = ST_GAP;
            dur_d   = '0;
        end
        adv = seg_end && (state_q == ST_GAP);
`else
        adv = seg_end;
`endif

        if (adv) begin
            if (idx_q == last_idx) begin
                state_d = ST_IDLE;
                sfx_d   = SFX_NONE;
                idx_d   = '0;
                dur_d   = '0;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + 2'd1;
                load  = 1'b1;
            end
        end

        // A running OVER can be neither restarted nor preempted.
        if (over_trig && sfx_q != SFX_OVER) begin
            sfx_d  = SFX_OVER;
            idx_d  = '0;
            load   = 1'b1;
            done_d = 1'b0;
        end else if (hit_trig && sfx_q != SFX_OVER) begin
            sfx_d  = SFX_HIT;
            idx_d  = '0;
            load   = 1'b1;
            done_d = 1'b0;
        end

        if (load) begin
            nxt     = note_rom(sfx_d, idx_d);
            state_d = ST_NOTE;
            half_d  = nxt.half;
            len_d   = nxt.len;
            presc_d = '0;
            dur_d   = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sfx_q   <= SFX_NONE;
            idx_q   <= '0;
            half_q  <= '0;
            len_q   <= '0;
            presc_q <= '0;
            dur_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sfx_q   <= sfx_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            len_q   <= len_d;
            presc_q <= presc_d;
            dur_q   <= dur_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    sq_tone_gen u_tone (
        .clk     (clk),
        .reset   (reset),
        .clear   (load),
        .enable  (state_d == ST_NOTE),
        .half    (half_q),
        .speaker (speaker)
    );

    assign busy       = busy_q;
    assign active_sfx = sfx_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sfx_player.sv
// tb_sfx_player: directed checks of jingle timing, priority and reset.
// Runs at CLK_FREQ = 1 MHz so one ms tick is 1000 cycles.
module tb_sfx_player;

    localparam int CLK_FREQ = 1_000_000;
`ifdef SFX_GAP_EN
    localparam int GAP = 10_000;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       hit_trig;
    logic       over_trig;
    logic       speaker;
    logic       busy;
    logic [1:0] active_sfx;
    logic       done;

    int n_chk = 0;
    int n_err = 0;
    int t = 0;
    int done_cnt = 0;
    int d0;

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    sfx_player #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .hit_trig   (hit_trig),
        .over_trig  (over_trig),
        .speaker    (speaker),
        .busy       (busy),
        .active_sfx (active_sfx),
        .done       (done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic step_to(input int target);
        while (t < target) step();
    endtask

    task automatic spk_until(input logic v, input int lim);
        int k = 0;
        while (speaker !== v && k < lim) begin
            step();
            k++;
        end
    endtask

    task automatic done_until(input int lim);
        int k = 0;
        while (done !== 1'b1 && k < lim) begin
            step();
            k++;
        end
    endtask

    task automatic fire(input logic h, input logic o);
        @(negedge clk);
        hit_trig  = h;
        over_trig = o;
        step();
        hit_trig  = 1'b0;
        over_trig = 1'b0;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        hit_trig  = 1'b0;
        over_trig = 1'b0;
        #2 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_spk",  int'(speaker), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_act",  int'(active_sfx), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk) reset = 1'b1;
        repeat (10) step();
        chk("idle_spk",  int'(speaker), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_act",  int'(active_sfx), 0);
        chk("idle_done", done_cnt, 0);

        // HIT jingle
        d0 = done_cnt;
        fire(1'b1, 1'b0);
        t = 0;
        chk("hit_busy", int'(busy), 1);
        chk("hit_act",  int'(active_sfx), 1);
        spk_until(1'b1, 1000);
        chk("hit_rise", t, 568);
        spk_until(1'b0, 1000);
        chk("hit_fall", t, 1136);
        step_to(40000 + GAP);
        chk("hit_n1_spk", int'(speaker), 0);
        spk_until(1'b1, 1000);
        chk("hit_n1_rise", t, 40000 + GAP + 378);
        done_until(60000);
        chk("hit_done_t",    t, 80000 + 2 * GAP);
        chk("hit_done_busy", int'(busy), 0);
        chk("hit_done_act",  int'(active_sfx), 0);
        step();
        chk("hit_done_width", int'(done), 0);
        chk("hit_done_cnt",   done_cnt - d0, 1);

        // simultaneous triggers: OVER wins
        d0 = done_cnt;
        fire(1'b1, 1'b1);
        t = 0;
        chk("col_act",  int'(active_sfx), 2);
        chk("col_busy", int'(busy), 1);
        spk_until(1'b1, 2000);
        chk("ovr_rise0", t, 956);
        step_to(150000 + GAP);
        spk_until(1'b1, 2000);
        chk("ovr_rise1", t, 150000 + GAP + 1275);
        step_to(300000 + 2 * GAP);
        spk_until(1'b1, 2000);
        chk("ovr_rise2", t, 300000 + 2 * GAP + 1515);
        step_to(450000 + 3 * GAP);
        spk_until(1'b1, 3000);
        chk("ovr_rise3", t, 450000 + 3 * GAP + 1908);
        done_until(400000);
        chk("ovr_done_t", t, 750000 + 4 * GAP);
        step();
        chk("ovr_done_cnt", done_cnt - d0, 1);
        chk("ovr_end_act",  int'(active_sfx), 0);

        // HIT restart 60 ms in
        d0 = done_cnt;
        fire(1'b1, 1'b0);
        t = 0;
        step_to(60000);
        fire(1'b1, 1'b0);
        t = 0;
        chk("rs_act", int'(active_sfx), 1);
        chk("rs_spk", int'(speaker), 0);
        spk_until(1'b1, 1000);
        chk("rs_rise", t, 568);
        done_until(100000);
        chk("rs_done_t", t, 80000 + 2 * GAP);
        step();
        chk("rs_done_cnt", done_cnt - d0, 1);

        // OVER preempts HIT; HIT during OVER is ignored
        d0 = done_cnt;
        fire(1'b1, 1'b0);
        t = 0;
        step_to(20000);
        fire(1'b0, 1'b1);
        t = 0;
        chk("pre_act",  int'(active_sfx), 2);
        chk("pre_busy", int'(busy), 1);
        spk_until(1'b1, 2000);
        chk("pre_rise", t, 956);
        spk_until(1'b0, 2000);
        chk("pre_fall", t, 1912);
        step_to(1999);
        fire(1'b1, 1'b0);
        chk("ign_act", int'(active_sfx), 2);
        spk_until(1'b1, 2000);
        chk("ign_rise", t, 2868);
        chk("pre_no_done", done_cnt - d0, 0);

        // asynchronous reset mid-OVER
        step_to(3000);
        chk("ar_pre_spk", int'(speaker), 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_spk",  int'(speaker), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_act",  int'(active_sfx), 0);
        chk("ar_done", int'(done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2000) step();
        chk("ar_after_busy", int'(busy), 0);
        chk("ar_after_act",  int'(active_sfx), 0);
        chk("ar_after_spk",  int'(speaker), 0);
        chk("ar_no_done",    done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
